// File: rtl/inv_shift_row.sv
// AES InvShiftRows pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// Optional per-byte parity transport and checking is enabled by defining INV_SHIFT_ROW_PARITY_EN.
module inv_shift_row #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [0:127]     dataIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [0:127]     dataOut,
  output logic [CNT_W-1:0] blkCount
`ifdef INV_SHIFT_ROW_PARITY_EN
  ,
  input  logic [0:15]      dataInPar,
  output logic [0:15]      dataOutPar,
  output logic             parErr
`endif
);

  // Output byte 4c+r takes input byte 4*((c-r) mod 4)+r.
  function automatic logic [0:127] inv_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:15] byte_par(input logic [0:127] d);
    logic [0:15] p;
    p = '0;
    for (int k = 0; k < 16; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction

  logic [0:127]     main_data_q, main_data_d;
  logic [0:127]     skid_data_q, skid_data_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:127]     xf_s;
  logic             accept_s;
  logic             drain_s;
`ifdef INV_SHIFT_ROW_PARITY_EN
  logic [0:15]      main_par_q, main_par_d;
  logic [0:15]      skid_par_q, skid_par_d;
  logic             par_err_q, par_err_d;
  logic [0:15]      xf_par_s;
`endif

  assign xf_s     = inv_shift(dataIn);
  assign accept_s = inValid & ~skid_valid_q;
  assign drain_s  = main_valid_q & outReady;

  assign inReady  = ~skid_valid_q;
  assign outValid = main_valid_q;
  assign dataOut  = main_data_q;
  assign blkCount = cnt_q;
`ifdef INV_SHIFT_ROW_PARITY_EN
  assign xf_par_s   = byte_par(xf_s);
  assign dataOutPar = main_par_q;
  assign parErr     = par_err_q;
`endif

  // Next-state for main/skid storage, block counter and parity tracking.
  always_comb begin
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = accept_s ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
`ifdef INV_SHIFT_ROW_PARITY_EN
    main_par_d   = main_par_q;
    skid_par_d   = skid_par_q;
    par_err_d    = par_err_q | (accept_s & (dataInPar != byte_par(dataIn)));
`endif
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // inReady is low here, so the only possible event is promoting the skid entry.
      if (drain_s) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
`ifdef INV_SHIFT_ROW_PARITY_EN
        main_par_d   = skid_par_q;
`endif
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (!main_valid_q || drain_s) begin
      if (accept_s) begin
        main_data_d  = xf_s;
        main_valid_d = 1'b1;
`ifdef INV_SHIFT_ROW_PARITY_EN
        main_par_d   = xf_par_s;
`endif
      end else if (drain_s) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end else begin
      if (accept_s) begin
        skid_data_d  = xf_s;
        skid_valid_d = 1'b1;
`ifdef INV_SHIFT_ROW_PARITY_EN
        skid_par_d   = xf_par_s;
`endif
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data_q  <= '0;
      skid_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
`ifdef INV_SHIFT_ROW_PARITY_EN
      main_par_q   <= '0;
      skid_par_q   <= '0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
`ifdef INV_SHIFT_ROW_PARITY_EN
      main_par_q   <= main_par_d;
      skid_par_q   <= skid_par_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

endmodule
